pc_sequencer: RTL and testbench

//  Multi-cycle control FSM for the 8-bit core. Owns the PC, the instruction register (IR) and the
//  16-entry label table. Drives the decoder from IR and uses its control outputs to sequence the

---
 rtl/pc_sequencer.sv | 127 ++++++++++++
 tb/tb_pc_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer owning PC, IR and the label table; 3-5 cycles per instruction.
// Data-memory stalls hold MEM with dmem_req_o raised until dmem_ack_i; start_i is honoured only in IDLE or HALT.
module pc_sequencer #(
  parameter int PC_W  = 8,
  parameter int LBL_N = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  output logic [PC_W-1:0]  imem_addr_o,
  input  logic [7:0]       imem_data_i,
  output logic [7:0]       ir_o,
  input  logic [3:0]       alu_op_i,
  input  logic [3:0]       branch_addr_i,
  input  logic             mem_read_i,
  input  logic             mem_write_i,
  input  logic             label_read_i,
  input  logic             label_write_i,
  input  logic             reg_write_i,
  input  logic             halt_i,
  input  logic             zero_i,
  output logic             dmem_req_o,
  output logic             dmem_we_o,
  input  logic             dmem_ack_i,
  output logic             reg_we_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] cycle_cnt_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6
  } state_t;

  state_t           state;
  logic [PC_W-1:0]  pc;
  logic [7:0]       ir;
  logic [PC_W-1:0]  labelTbl [LBL_N];
  logic [CNT_W-1:0] cycleCnt;

  logic [PC_W-1:0]  pcInc;
  logic             inRun;
  logic             branchTaken;

  assign pcInc       = pc + 1'b1;
  assign inRun       = (state == FETCH) || (state == DECODE) || (state == EXEC) ||
                       (state == MEM) || (state == WB);
  assign branchTaken = (alu_op_i == 4'b1011) || ((alu_op_i == 4'b0101) && zero_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc       <= '0;
      ir       <= '0;
      cycleCnt <= '0;
      for (int i = 0; i < LBL_N; i++) labelTbl[i] <= '0;
    end else begin
      if (inRun && (cycleCnt != '1)) cycleCnt <= cycleCnt + 1'b1;
      case (state)
        IDLE, HALT: begin
          if (start_i) begin
            state    <= FETCH;
            pc       <= '0;
            cycleCnt <= '0;
          end
        end
        FETCH:  state <= DECODE;
        DECODE: begin
          ir    <= imem_data_i;
          state <= EXEC;
        end
        EXEC: begin
          // Decoder flags are mutually prioritised; halt wins, undefined opcodes fall through as nop.
          if (halt_i) begin
            state <= HALT;
          end else if (mem_read_i || mem_write_i) begin
            state <= MEM;
          end else if (label_read_i) begin
            pc    <= branchTaken ? labelTbl[branch_addr_i] : pcInc;
            state <= FETCH;
          end else if (label_write_i) begin
            labelTbl[ir[3:0]] <= pcInc;
            pc                <= pcInc;
            state             <= FETCH;
          end else if (reg_write_i) begin
            state <= WB;
          end else begin
            pc    <= pcInc;
            state <= FETCH;
          end
        end
        MEM: begin
          if (dmem_ack_i) begin
            if (mem_read_i) begin
              state <= WB;
            end else begin
              pc    <= pcInc;
              state <= FETCH;
            end
          end
        end
        WB: begin
          pc    <= pcInc;
          state <= FETCH;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign imem_addr_o = pc;
  assign ir_o        = ir;
  assign dmem_req_o  = (state == MEM);
  assign dmem_we_o   = (state == MEM) && mem_write_i;
  assign reg_we_o    = (state == WB);
  assign busy_o      = inRun;
  assign done_o      = (state == HALT);
  assign cycle_cnt_o = cycleCnt;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: ROM, decoder and data-memory models plus an event scoreboard
// (writeback, halt and memory-completion events, each tagged with pc and cycle count).
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [7:0]  imem_addr_o;
  logic [7:0]  imem_data_i;
  logic [7:0]  ir_o;
  logic [3:0]  alu_op_i;
  logic [3:0]  branch_addr_i;
  logic        mem_read_i, mem_write_i, label_read_i, label_write_i, reg_write_i, halt_i;
  logic        zero_i;
  logic        dmem_req_o, dmem_we_o;
  logic        dmem_ack_i = 1'b0;
  logic        reg_we_o, busy_o, done_o;
  logic [15:0] cycle_cnt_o;

  pc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i),
    .imem_addr_o(imem_addr_o), .imem_data_i(imem_data_i), .ir_o(ir_o),
    .alu_op_i(alu_op_i), .branch_addr_i(branch_addr_i),
    .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
    .label_read_i(label_read_i), .label_write_i(label_write_i),
    .reg_write_i(reg_write_i), .halt_i(halt_i), .zero_i(zero_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_ack_i(dmem_ack_i),
    .reg_we_o(reg_we_o), .busy_o(busy_o), .done_o(done_o), .cycle_cnt_o(cycle_cnt_o)
  );

  always #5 clk = ~clk;

  // Instruction ROM: synchronous, data one cycle after the address.
  logic [7:0] rom [256];
  always @(posedge clk) imem_data_i <= rom[imem_addr_o];

  // Decoder: 0x0 add, 0x1 ld, 0x2 st, 0x3 label, 0x4 j, 0x5 beq0, 0xE halt, else undefined.
  always_comb begin
    alu_op_i      = 4'b0000;
    branch_addr_i = ir_o[3:0];
    mem_read_i    = 1'b0;
    mem_write_i   = 1'b0;
    label_read_i  = 1'b0;
    label_write_i = 1'b0;
    reg_write_i   = 1'b0;
    halt_i        = 1'b0;
    case (ir_o[7:4])
      4'h0: reg_write_i = 1'b1;
      4'h1: begin mem_read_i = 1'b1; reg_write_i = 1'b1; end
      4'h2: mem_write_i = 1'b1;
      4'h3: label_write_i = 1'b1;
      4'h4: begin label_read_i = 1'b1; alu_op_i = 4'b1011; end
      4'h5: begin label_read_i = 1'b1; alu_op_i = 4'b0101; end
      4'hE: halt_i = 1'b1;
      default: ;
    endcase
  end

  // Zero flag is high while the run's cycle count sits in [zLo, zHi).
  int zLo = 0, zHi = 0;
  assign zero_i = (int'(cycle_cnt_o) >= zLo) && (int'(cycle_cnt_o) < zHi);

  // Data memory: ack once the request has been up for more than the configured delay.
  int ldDelay = 0, stDelay = 0, waitN = 0;
  initial forever begin
    @(posedge clk);
    #1;
    if (dmem_req_o) begin
      waitN++;
      dmem_ack_i = (waitN > (dmem_we_o ? stDelay : ldDelay));
    end else begin
      waitN = 0;
      dmem_ack_i = 1'b0;
    end
  end

  int nChecks = 0, nPass = 0;

  task automatic chk(input string name, input int act, input int exp);
    nChecks++;
    if (act == exp) nPass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Event kinds: 1 writeback, 2 halt entry, 3 load done, 4 store done.
  typedef struct {int kind; int pc; int val;} ev_t;
  ev_t expQ[$];

  task automatic pushExp(input int k, input int p, input int v);
    ev_t e;
    e.kind = k; e.pc = p; e.val = v;
    expQ.push_back(e);
  endtask

  task automatic seen(input int k, input int p, input int v);
    ev_t e;
    nChecks++;
    if (expQ.size() == 0) begin
      $display("FAIL unexpected_event: got kind=%0d pc=%0d val=%0d, expected none", k, p, v);
    end else begin
      e = expQ.pop_front();
      if (k == e.kind && p == e.pc && v == e.val) nPass++;
      else $display("FAIL event: got kind=%0d pc=%0d val=%0d, expected kind=%0d pc=%0d val=%0d",
                    k, p, v, e.kind, e.pc, e.val);
    end
  endtask

  // Monitor: independent of stimulus, samples on the falling edge.
  int  reqRun = 0;
  logic donePrev = 1'b0;
  initial forever begin
    @(negedge clk);
    if (!rst_n || !dmem_req_o) reqRun = 0;
    else reqRun++;
    if (dmem_req_o && dmem_ack_i) begin
      seen(dmem_we_o ? 4 : 3, int'(imem_addr_o), reqRun);
      reqRun = 0;
    end
    if (reg_we_o) seen(1, int'(imem_addr_o), int'(cycle_cnt_o));
    if (done_o && !donePrev) seen(2, int'(imem_addr_o), int'(cycle_cnt_o));
    donePrev = done_o;
  end

  task automatic runProg(input string name, input int limit, output int cyc);
    @(negedge clk); start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    cyc = 1;
    while (!done_o && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
    chk({name, "_halt_reached"}, int'(done_o), 1);
  endtask

  int cyc;

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'hF0;
    #23;
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_cnt", int'(cycle_cnt_o), 0);
    chk("rst_pc", int'(imem_addr_o), 0);
    chk("rst_ir", int'(ir_o), 0);
    chk("rst_strobes", int'({reg_we_o, dmem_req_o}), 0);
    @(negedge clk); rst_n = 1'b1;

    // Run 1: lone halt.
    rom[0] = 8'hE0;
    pushExp(2, 0, 3);
    runProg("r1", 100, cyc);
    chk("r1_done_cycle", cyc, 4);

    // Run 2: add then halt.
    rom[0] = 8'h04; rom[1] = 8'hE0;
    pushExp(1, 0, 3);
    pushExp(2, 1, 7);
    runProg("r2", 100, cyc);

    // Run 3a: label[7] <= 8 in front of a halt at 8.
    for (int i = 0; i < 7; i++) rom[i] = 8'hF0;
    rom[7] = 8'h37; rom[8] = 8'hE0;
    pushExp(2, 8, 27);
    runProg("r3a", 200, cyc);

    // Run 3b: label write at pc 2, beq0 not taken, j back to 3, beq0 taken to label 7.
    rom[0] = 8'hF0; rom[1] = 8'hF0; rom[2] = 8'h33; rom[3] = 8'h04;
    rom[4] = 8'h57; rom[5] = 8'h43;
    zLo = 20; zHi = 65536;
    pushExp(1, 3, 12);
    pushExp(1, 3, 22);
    pushExp(2, 8, 29);
    runProg("r3b", 200, cyc);
    zLo = 0; zHi = 0;

    // Run 4: ld with 5-cycle ack delay, then st with immediate ack.
    rom[0] = 8'h10; rom[1] = 8'h20; rom[2] = 8'hE0;
    ldDelay = 5; stDelay = 0;
    pushExp(3, 0, 6);
    pushExp(1, 0, 9);
    pushExp(4, 1, 1);
    pushExp(2, 2, 17);
    runProg("r4", 200, cyc);

    // Run 5a: label[9] <= 2.
    rom[0] = 8'hF0; rom[1] = 8'h39; rom[2] = 8'hE0;
    pushExp(2, 2, 9);
    runProg("r5a", 100, cyc);

    // Run 5b: taken beq0 to 2, nops through 0xFF wrap to 0, beq0 falls through to halt at 1.
    rom[0] = 8'h59; rom[1] = 8'hE0;
    for (int i = 2; i < 256; i++) rom[i] = 8'hF0;
    zLo = 0; zHi = 10;
    pushExp(2, 1, 771);
    fork
      begin
        repeat (100) @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        chk("r5_busy_after_start", int'(busy_o), 1);
      end
    join_none
    runProg("r5b", 2000, cyc);
    zLo = 0; zHi = 0;

    // Run 6: async reset while a load waits for its ack.
    rom[0] = 8'hF0; rom[1] = 8'h10; ldDelay = 50;
    @(negedge clk); start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    cyc = 0;
    while (!dmem_req_o && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("r6_req_seen", int'(dmem_req_o), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("r6_req_dropped", int'(dmem_req_o), 0);
    chk("r6_busy", int'(busy_o), 0);
    chk("r6_cnt", int'(cycle_cnt_o), 0);
    chk("r6_pc", int'(imem_addr_o), 0);
    chk("r6_ir", int'(ir_o), 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    ldDelay = 0;

    // Run 6b: beq0 taken to label 7 must land on 0 after the reset cleared the table.
    rom[0] = 8'h57; rom[1] = 8'hE0; rom[8] = 8'hE0;
    zLo = 0; zHi = 3;
    pushExp(2, 1, 9);
    runProg("r6b", 200, cyc);

    repeat (3) @(negedge clk);
    chk("pending_events", expQ.size(), 0);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
